// File: rtl/rgbled_pkg.sv
// rgbled_pkg: shared types and timing helper for the WS281x chain controller.
package rgbled_pkg;
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_GAP} rgbled_state_e;

  function automatic int ns_to_cycles(input int clk_freq, input int ns);
    return (clk_freq / 1_000_000 * ns) / 1000;
  endfunction
endpackage

// File: rtl/rgbled_chain_ctrl_bit_ser.sv
// rgbled_bit_ser: 24-bit GRB shifter with the shared HIGH/LOW/GAP down-counter.
module rgbled_bit_ser #(
  parameter int T0H  = 10,
  parameter int T1H  = 20,
  parameter int TBit = 31,
  parameter int TRst = 2000,
  parameter int TW   = 11
) (
  input  logic        main_clk_buf,
  input  logic        rst_sys_n,
  input  logic        load,
  input  logic [23:0] word,
  input  logic        start,
  input  logic        gap,
  output logic        dout,
  output logic        bit_done
);
  logic [23:0]   r_sr;
  logic [TW-1:0] r_tmr;
  logic          r_hi;
  logic          r_dout;
  logic          w_nb;
  assign w_nb     = load ? word[23] : r_sr[22];
  assign bit_done = r_tmr == '0;
  assign dout     = r_dout;
  // bit_done marks the last cycle of whichever phase the counter is timing
  always_ff @(posedge main_clk_buf or negedge rst_sys_n)
    if (!rst_sys_n) begin
      r_sr   <= '0;
      r_tmr  <= '0;
      r_hi   <= 1'b0;
      r_dout <= 1'b0;
    end else if (gap) begin
      r_hi   <= 1'b0;
      r_dout <= 1'b0;
      r_tmr  <= TW'(TRst - 1);
    end else if (load || start) begin
      r_sr   <= load ? word : {r_sr[22:0], 1'b0};
      r_hi   <= 1'b1;
      r_dout <= 1'b1;
      r_tmr  <= w_nb ? TW'(T1H - 1) : TW'(T0H - 1);
    end else if (r_tmr != '0) begin
      r_tmr <= r_tmr - TW'(1);
    end else if (r_hi) begin
      r_hi   <= 1'b0;
      r_dout <= 1'b0;
      r_tmr  <= r_sr[23] ? TW'(TBit - T1H - 1) : TW'(TBit - T0H - 1);
    end
endmodule

// File: rtl/rgbled_chain_ctrl.sv
// rgbled_chain_ctrl: WS281x chain driver with double-buffered colours,
// on-demand or auto-refresh frames and a latch gap after every frame.
module rgbled_chain_ctrl
  import rgbled_pkg::*;
#(
  parameter int ClkFreq = 25_000_000,
  parameter int NumLeds = 2,
  parameter int T0HNs   = 400,
  parameter int T1HNs   = 800,
  parameter int TBitNs  = 1250,
  parameter int TRstNs  = 80_000,
  localparam int IW     = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
  input  logic          main_clk_buf,
  input  logic          rst_sys_n,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [23:0]   wr_data_i,
  input  logic          go_i,
  input  logic          auto_refresh_i,
  output logic          busy_o,
  output logic          frame_done_o,
  output logic          dout_o
);
  localparam int T0H  = ns_to_cycles(ClkFreq, T0HNs);
  localparam int T1H  = ns_to_cycles(ClkFreq, T1HNs);
  localparam int TBit = ns_to_cycles(ClkFreq, TBitNs);
  localparam int TRst = ns_to_cycles(ClkFreq, TRstNs);
  localparam int TW   = $clog2(TRst + 1);

  if (NumLeds < 1 || T0H < 1 || T1H >= TBit) begin : g_bad_cfg
    $error("rgbled_chain_ctrl: invalid LED count or bit timing");
  end

  rgbled_state_e r_state, w_next;
  rgb_t          r_wbuf [NumLeds];
  rgb_t          r_shad [NumLeds];
  rgb_t          w_word;
  logic [4:0]    r_bit;
  logic [IW-1:0] r_led, w_nled;
  logic          r_pend;
  logic          w_load, w_start, w_gap, w_bd, w_req, w_last;

  assign w_req        = r_pend | go_i | auto_refresh_i;
  assign w_last       = r_led == IW'(NumLeds - 1);
  assign w_nled       = r_led + IW'(1);
  // LOAD feeds LED 0 straight from the write buffer while the shadow copy lands
  assign w_word       = (r_state == S_LOAD) ? r_wbuf[0] : r_shad[w_nled];
  assign busy_o       = r_state != S_IDLE;
  assign frame_done_o = r_state == S_GAP && w_bd;

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_start = 1'b0;
    w_gap   = 1'b0;
    case (r_state)
      S_IDLE: w_next = w_req ? S_LOAD : S_IDLE;
      S_LOAD: begin
        w_next = S_HIGH;
        w_load = 1'b1;
      end
      S_HIGH: w_next = w_bd ? S_LOW : S_HIGH;
      S_LOW: if (w_bd) begin
        w_next  = (r_bit == 5'd23 && w_last) ? S_GAP : S_HIGH;
        w_gap   = r_bit == 5'd23 && w_last;
        w_load  = r_bit == 5'd23 && !w_last;
        w_start = r_bit != 5'd23;
      end
      S_GAP: w_next = w_bd ? (w_req ? S_LOAD : S_IDLE) : S_GAP;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge main_clk_buf or negedge rst_sys_n)
    if (!rst_sys_n) begin
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_led   <= '0;
      r_pend  <= 1'b0;
      for (int i = 0; i < NumLeds; i++) begin
        r_wbuf[i] <= '0;
        r_shad[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_pend  <= (w_next == S_LOAD) ? 1'b0 : r_pend | (go_i && r_state != S_LOAD);
      if (r_state == S_LOAD) begin
        r_bit  <= '0;
        r_led  <= '0;
        r_shad <= r_wbuf;
      end else if (r_state == S_LOW && w_bd) begin
        r_bit <= (r_bit == 5'd23) ? 5'd0 : r_bit + 5'd1;
        r_led <= (r_bit == 5'd23) ? w_nled : r_led;
      end
      if (wr_en_i && int'(wr_idx_i) < NumLeds) r_wbuf[wr_idx_i] <= wr_data_i;
    end

  rgbled_bit_ser #(
    .T0H (T0H),
    .T1H (T1H),
    .TBit(TBit),
    .TRst(TRst),
    .TW  (TW)
  ) u_ser (
    .main_clk_buf(main_clk_buf),
    .rst_sys_n   (rst_sys_n),
    .load        (w_load),
    .word        (w_word),
    .start       (w_start),
    .gap         (w_gap),
    .dout        (dout_o),
    .bit_done    (w_bd)
  );
endmodule

// File: tb/tb_rgbled_chain_ctrl.sv
// tb_rgbled_chain_ctrl: directed checks of frame timing, buffering, requests,
// auto-refresh, reset and a single-LED 50 MHz configuration.
module tb_rgbled_chain_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, wr_en_a, go_a, auto_a;
  logic [0:0]  idx_a;
  logic [23:0] wd_a;
  logic        busy_a, done_a, dout_a;
  logic        rst_b_n, wr_en_b, go_b, auto_b;
  logic [0:0]  idx_b;
  logic [23:0] wd_b;
  logic        busy_b, done_b, dout_b;
  logic        sel;
  int          ncmp = 0;
  int          nerr = 0;

  rgbled_chain_ctrl u_a (
    .main_clk_buf(clk), .rst_sys_n(rst_a_n), .wr_en_i(wr_en_a), .wr_idx_i(idx_a),
    .wr_data_i(wd_a), .go_i(go_a), .auto_refresh_i(auto_a),
    .busy_o(busy_a), .frame_done_o(done_a), .dout_o(dout_a)
  );

  rgbled_chain_ctrl #(.ClkFreq(50_000_000), .NumLeds(1)) u_b (
    .main_clk_buf(clk), .rst_sys_n(rst_b_n), .wr_en_i(wr_en_b), .wr_idx_i(idx_b),
    .wr_data_i(wd_b), .go_i(go_b), .auto_refresh_i(auto_b),
    .busy_o(busy_b), .frame_done_o(done_b), .dout_o(dout_b)
  );

  wire s_dout = sel ? dout_b : dout_a;
  wire s_done = sel ? done_b : done_a;
  wire s_busy = sel ? busy_b : busy_a;

  task automatic chk(input string tag, input int obs, input int exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_go(input logic v);
    if (sel) go_b = v; else go_a = v;
  endtask

  task automatic wr(input logic idx, input logic [23:0] d);
    @(negedge clk);
    if (sel) begin wr_en_b = 1'b1; idx_b = idx; wd_b = d; end
    else begin wr_en_a = 1'b1; idx_a = idx; wd_a = d; end
    @(negedge clk);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  // exp holds the transmitted bits in order, first bit at exp[nb-1]
  task automatic frame(input string tag, input bit pulse_go, input int nb,
                       input logic [47:0] exp, input int t0h, input int t1h,
                       input int tbit, input int trst);
    int lat, h, l, eh, ones;
    if (pulse_go) begin
      @(negedge clk);
      set_go(1'b1);
      @(negedge clk);
      set_go(1'b0);
    end
    lat = 0;
    while (!s_dout && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("%s start", tag), int'(s_dout), 1);
    if (pulse_go) chk($sformatf("%s latency", tag), lat, 1);
    for (int k = 0; k < nb; k++) begin
      eh = exp[nb-1-k] ? t1h : t0h;
      h = 0;
      while (s_dout && h < 5000) begin
        @(negedge clk);
        h++;
      end
      chk($sformatf("%s bit%0d high", tag, k), h, eh);
      l = 0;
      if (k < nb - 1) begin
        while (!s_dout && l < 5000) begin
          @(negedge clk);
          l++;
        end
        chk($sformatf("%s bit%0d period", tag, k), h + l, tbit);
      end else begin
        ones = 0;
        while (l < 10000) begin
          l++;
          if (s_dout) ones++;
          if (s_done) break;
          @(negedge clk);
        end
        chk($sformatf("%s tail+gap", tag), l, tbit - eh + trst);
        chk($sformatf("%s gap low", tag), ones, 0);
        @(negedge clk);
        chk($sformatf("%s done single", tag), int'(s_done), 0);
      end
    end
  endtask

  initial begin
    sel = 1'b0;
    rst_a_n = 1'b0; wr_en_a = 1'b0; go_a = 1'b0; auto_a = 1'b0; idx_a = '0; wd_a = '0;
    rst_b_n = 1'b0; wr_en_b = 1'b0; go_b = 1'b0; auto_b = 1'b0; idx_b = '0; wd_b = '0;
    repeat (3) @(negedge clk);
    chk("rst dout", int'(dout_a), 0);
    chk("rst busy", int'(busy_a), 0);
    chk("rst done", int'(done_a), 0);
    chk("rst b busy", int'(busy_b), 0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    wr(1'b0, 24'h800001);
    wr(1'b1, 24'h000000);
    frame("f1", 1, 48, {24'h800001, 24'h000000}, 10, 20, 31, 2000);
    chk("f1 idle", int'(s_busy), 0);

    fork
      frame("f2", 1, 48, {24'h800001, 24'h000000}, 10, 20, 31, 2000);
      begin
        repeat (100) @(negedge clk);
        wr(1'b1, 24'hFFFFFF);
      end
    join
    chk("f2 idle", int'(s_busy), 0);
    frame("f3", 1, 48, {24'h800001, 24'hFFFFFF}, 10, 20, 31, 2000);

    fork
      frame("f4", 1, 48, {24'h800001, 24'hFFFFFF}, 10, 20, 31, 2000);
      begin
        for (int p = 0; p < 3; p++) begin
          repeat (100) @(negedge clk);
          go_a = 1'b1;
          @(negedge clk);
          go_a = 1'b0;
        end
      end
    join
    chk("f4 reload busy", int'(s_busy), 1);
    frame("f5", 0, 48, {24'h800001, 24'hFFFFFF}, 10, 20, 31, 2000);
    repeat (5) @(negedge clk);
    chk("f5 idle", int'(s_busy), 0);

    auto_a = 1'b1;
    frame("a1", 0, 48, {24'h800001, 24'hFFFFFF}, 10, 20, 31, 2000);
    chk("a1 repeat busy", int'(s_busy), 1);
    fork
      frame("a2", 0, 48, {24'h800001, 24'hFFFFFF}, 10, 20, 31, 2000);
      begin
        repeat (300) @(negedge clk);
        auto_a = 1'b0;
      end
    join
    chk("a2 idle", int'(s_busy), 0);

    @(negedge clk);
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pre-reset dout", int'(dout_a), 1);
    rst_a_n = 1'b0;
    #1;
    chk("async rst dout", int'(dout_a), 0);
    chk("async rst busy", int'(busy_a), 0);
    chk("async rst done", int'(done_a), 0);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    frame("r1", 1, 48, 48'h0, 10, 20, 31, 2000);
    chk("r1 idle", int'(s_busy), 0);

    sel = 1'b1;
    wr(1'b0, 24'hA5000F);
    frame("b1", 1, 24, {24'h0, 24'hA5000F}, 20, 40, 62, 4000);
    wr(1'b1, 24'hFFFFFF);
    frame("b2", 1, 24, {24'h0, 24'hA5000F}, 20, 40, 62, 4000);
    chk("b2 idle", int'(s_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
